// File: rtl/pipelined_control_unit.sv
// Control unit for the 4-stage ID/EX/MEM/WB core.
// Decodes the ID opcode into a control bundle and carries it through the
// EX, MEM and WB pipeline registers. Also owns hazard control (memory
// freeze, branch flush and load-use interlock) and a saturating stall counter.
module pipelined_control_unit #(
    parameter int REG_ADDR_W  = 4,
    parameter bit HAZARD_EN   = 1'b1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [3:0]             id_opcode,
    input  logic [REG_ADDR_W-1:0]  id_rs1,
    input  logic [REG_ADDR_W-1:0]  id_rs2,
    input  logic [REG_ADDR_W-1:0]  id_rd,
    input  logic                   branch_taken,
    input  logic                   mem_busy,
    output logic                   stall_if,
    output logic                   flush_ifid,
    output logic                   ex_valid,
    output logic [1:0]             ex_branch_sel,
    output logic [1:0]             ex_ext_sel,
    output logic                   ex_alu_b_sel,
    output logic [1:0]             ex_alu_ctrl,
    output logic                   ex_set_flags,
    output logic                   mem_valid,
    output logic                   mem_we,
    output logic                   mem_byte,
    output logic [REG_ADDR_W-1:0]  mem_rd,
    output logic                   wb_valid,
    output logic                   wb_rf_we,
    output logic                   wb_sel,
    output logic [REG_ADDR_W-1:0]  wb_rd,
    output logic [STALL_CNT_W-1:0] stall_count
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_B    = 4'h1,
        OP_BEQ  = 4'h2,
        OP_BLT  = 4'h3,
        OP_LW   = 4'h4,
        OP_LB   = 4'h5,
        OP_SW   = 4'h6,
        OP_SB   = 4'h7,
        OP_ADD  = 4'h8,
        OP_ADDI = 4'h9,
        OP_SUB  = 4'hA,
        OP_SHR  = 4'hB,
        OP_SHL  = 4'hC
    } opcode_e;

    // Field order follows the decode table; mem_byte rides along at the end.
    typedef struct packed {
        logic [1:0] branch_sel;
        logic       rf_we;
        logic [1:0] ext_sel;
        logic       alu_b_sel;
        logic [1:0] alu_ctrl;
        logic       set_flags;
        logic       mem_we;
        logic       wb_sel;
        logic       mem_byte;
    } ctrl_t;

    typedef struct packed {
        logic                  valid;
        ctrl_t                 ctrl;
        logic [REG_ADDR_W-1:0] rd;
    } ex_stage_t;

    typedef struct packed {
        logic                  valid;
        logic                  rf_we;
        logic                  mem_we;
        logic                  mem_byte;
        logic                  wb_sel;
        logic [REG_ADDR_W-1:0] rd;
    } mem_stage_t;

    typedef struct packed {
        logic                  valid;
        logic                  rf_we;
        logic                  wb_sel;
        logic [REG_ADDR_W-1:0] rd;
    } wb_stage_t;

    localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    opcode_e    op;
    ctrl_t      dec;
    logic       rs1_used;
    logic       rs2_used;
    logic       freeze;
    logic       flush;
    logic       lu_stall;
    ex_stage_t  ex_q;
    ex_stage_t  ex_next;
    mem_stage_t mem_q;
    wb_stage_t  wb_q;

    assign op = opcode_e'(id_opcode);

    // Opcode decode into the control bundle; undefined opcodes decode to zeros.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        dec = '0;
        case (op)
            OP_B:    dec = ctrl_t'({2'b01, 1'b0, 2'b10, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0});
            OP_BEQ:  dec = ctrl_t'({2'b10, 1'b0, 2'b10, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0});
            OP_BLT:  dec = ctrl_t'({2'b11, 1'b0, 2'b10, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0});
            OP_LW:   dec = ctrl_t'({2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0});
            OP_LB:   dec = ctrl_t'({2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1});
            OP_SW:   dec = ctrl_t'({2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0});
            OP_SB:   dec = ctrl_t'({2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1});
            OP_ADD:  dec = ctrl_t'({2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0});
            OP_ADDI: dec = ctrl_t'({2'b00, 1'b1, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0});
            OP_SUB:  dec = ctrl_t'({2'b00, 1'b1, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0});
            OP_SHR:  dec = ctrl_t'({2'b00, 1'b1, 2'b00, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0});
            OP_SHL:  dec = ctrl_t'({2'b00, 1'b1, 2'b00, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0});
            default: dec = '0;
        endcase
    end

    // Source-register usage of the ID instruction, for the load-use check.
    always_comb begin
        rs1_used = (op != OP_NOP) && (op != OP_B);
        rs2_used = op inside {OP_BEQ, OP_BLT, OP_SW, OP_SB, OP_ADD, OP_SUB};
    end

    // Hazard detection in priority order: freeze, then flush, then load-use.
    always_comb begin
        freeze   = mem_busy;
        flush    = ex_q.valid && (ex_q.ctrl.branch_sel != 2'b00) && branch_taken;
        lu_stall = HAZARD_EN && id_valid && ex_q.valid && ex_q.ctrl.wb_sel &&
                   (ex_q.rd != '0) &&
                   ((rs1_used && (id_rs1 == ex_q.rd)) || (rs2_used && (id_rs2 == ex_q.rd)));
        // Gating with rst_n keeps mem_busy from raising a stall while the core is held in reset.
        stall_if   = rst_n && (freeze || (!flush && lu_stall));
        flush_ifid = rst_n && !freeze && flush;
    end

    // Next EX contents: a bubble on flush or load-use, otherwise the decoded ID instruction.
    always_comb begin
        ex_next = '0;
        if (!flush && !lu_stall && id_valid) begin
            ex_next.valid = 1'b1;
            ex_next.ctrl  = dec;
            ex_next.rd    = id_rd;
        end
    end

    // Pipeline registers: all hold while frozen, otherwise EX loads and MEM/WB advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!freeze) begin
            // NOTE: non-blocking assignments let every stage sample the previous stage's old value on the same edge.
            ex_q           <= ex_next;
            mem_q.valid    <= ex_q.valid;
            mem_q.rf_we    <= ex_q.ctrl.rf_we;
            mem_q.mem_we   <= ex_q.ctrl.mem_we;
            mem_q.mem_byte <= ex_q.ctrl.mem_byte;
            mem_q.wb_sel   <= ex_q.ctrl.wb_sel;
            mem_q.rd       <= ex_q.rd;
            wb_q.valid     <= mem_q.valid;
            wb_q.rf_we     <= mem_q.rf_we;
            wb_q.wb_sel    <= mem_q.wb_sel;
            wb_q.rd        <= mem_q.rd;
        end
    end

    // Saturating count of cycles in which IF was held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall_if && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_ONE;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_branch_sel = ex_q.ctrl.branch_sel;
    assign ex_ext_sel    = ex_q.ctrl.ext_sel;
    assign ex_alu_b_sel  = ex_q.ctrl.alu_b_sel;
    assign ex_alu_ctrl   = ex_q.ctrl.alu_ctrl;
    assign ex_set_flags  = ex_q.ctrl.set_flags;
    assign mem_valid     = mem_q.valid;
    assign mem_we        = mem_q.mem_we;
    assign mem_byte      = mem_q.mem_byte;
    assign mem_rd        = mem_q.rd;
    assign wb_valid      = wb_q.valid;
    assign wb_rf_we      = wb_q.rf_we;
    assign wb_sel        = wb_q.wb_sel;
    assign wb_rd         = wb_q.rd;

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Next-generation control unit for the 4-stage (ID/EX/MEM/WB) core.
- Decodes the 4-bit opcode in ID into a control bundle and carries it through the EX, MEM and WB pipeline registers.
- Owns pipeline hazard control: load-use interlock, branch flush, and a global freeze while data memory is busy.
- Also keeps a saturating stall-cycle counter for performance debug.

Parameters:
- REG_ADDR_W, 4, width of register-file addresses rs1/rs2/rd.
- HAZARD_EN, 1, 1 enables the load-use interlock; 0 never asserts a load-use stall (the compiler schedules around it).
- STALL_CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_opcode  in  4  opcode in ID.
- id_rs1, id_rs2, id_rd  in  REG_ADDR_W each  register fields in ID.
- branch_taken  in  1  from EX flag logic; meaningful only when ex_branch_sel != 0.
- mem_busy  in  1  data memory not ready; freezes the pipeline.
- stall_if  out  1  hold PC and the IF/ID register.
- flush_ifid  out  1  load a bubble into IF/ID.
- ex_valid, ex_branch_sel[2], ex_ext_sel[2], ex_alu_b_sel, ex_alu_ctrl[2], ex_set_flags  out  EX-stage controls.
- mem_valid, mem_we, mem_byte, mem_rd[REG_ADDR_W]  out  MEM-stage controls.
- wb_valid, wb_rf_we, wb_sel, wb_rd[REG_ADDR_W]  out  WB-stage controls.
- stall_count  out  STALL_CNT_W  saturating count of stall_if cycles.

Behaviour:
- Decode is combinational in ID. Field order is branch_sel[1:0], rf_we, ext_sel[1:0], alu_b_sel, alu_ctrl[1:0], set_flags, mem_we, wb_sel:
  - 0000 NOP: all 0.
  - 0001 B: 01,0,10,0,01,1,0,0.
  - 0010 BEQ: 10,0,10,0,01,1,0,0.
  - 0011 BLT: 11,0,10,0,01,1,0,0.
  - 0100 LW / 0101 LB: 00,1,00,0,00,0,0,1.
  - 0110 SW / 0111 SB: 00,0,00,0,00,0,1,0.
  - 1000 ADD: 00,1,00,0,00,0,0,0.
  - 1001 ADDI: 00,1,01,1,00,0,0,0.
  - 1010 SUB: 00,1,00,0,01,0,0,0.
  - 1011 SHR: 00,1,00,1,10,0,0,0.
  - 1100 SHL: 00,1,00,1,11,0,0,0.
  - 1101-1111: all 0.
  - mem_byte = 1 for 0101 and 0111.
- Source usage:
  - rs1 is used by every non-NOP opcode except 0001.
  - rs2 is used by 0010, 0011, 0110, 0111, 1000, 1010.
- Bubble: all bundle bits 0, valid 0, rd 0. Every stage output equals its registered value, so invalid stages present all-zero controls.
- Reset: all stage registers and stall_count reset to 0 asynchronously; stall_if = 0 and flush_ifid = 0 during and after reset.
- Per rising edge, the first applicable rule wins:
  1. freeze = mem_busy. EX, MEM and WB registers hold; stall_if = 1; flush_ifid = 0. A pending branch_taken is ignored while frozen and acts once freeze drops, because EX holds the branch.
  2. flush = ex_valid & (ex_branch_sel != 0) & branch_taken. EX loads a bubble, MEM <- EX, WB <- MEM; flush_ifid = 1; stall_if = 0.
  3. lu_stall = HAZARD_EN & id_valid & ex_valid & ex_wb_sel & (ex_rd != 0) & ((rs1 used & id_rs1 == ex_rd) | (rs2 used & id_rs2 == ex_rd)). EX loads a bubble, MEM/WB advance, stall_if = 1. This costs exactly 1 stall cycle per load-use pair.
  4. Otherwise: EX <- decode of ID (valid = id_valid; bundle zeroed if !id_valid), MEM <- EX, WB <- MEM.
- stall_if and flush_ifid are combinational from the current state and inputs (no added latency).
- Bundle latency: ID to EX 1 cycle, to MEM 2 cycles, to WB 3 cycles.
- stall_count increments on every cycle with stall_if = 1 and saturates at all-ones; no wrap.
- Reset asserted mid-operation clears every in-flight instruction; no partial state survives.

Test Plan:
- Reset: rst_n low mid-stream -> all outputs 0 immediately, stall_count = 0. After release, feed ADDI (1001) with id_valid -> ex_alu_b_sel = 1, ex_ext_sel = 01 one cycle later; wb_rf_we = 1 three cycles later.
- Load-use: LW rd = 3, then ADD rs1 = 3 -> stall_if = 1 for exactly 1 cycle, EX bubble, ADD reaches EX one cycle late, stall_count = 1. Same sequence with HAZARD_EN = 0 -> no stall. ADD with rs2 = 3 also stalls; rd = 0 never stalls.
- Branch: BEQ in EX with branch_taken = 1 -> flush_ifid = 1 that cycle, next ex_valid = 0. With branch_taken = 0 -> no flush, BEQ advances to MEM.
- Freeze priority: mem_busy = 1 for 3 cycles while BEQ is in EX with branch_taken = 1 and a load-use pair pending -> all stages hold, stall_if = 1, flush_ifid = 0, stall_count += 3. After release -> flush_ifid = 1 on the first free cycle.
- Saturation and undefined opcodes: STALL_CNT_W = 2 with 5 stall cycles -> stall_count = 3. Opcodes 1101-1111 with id_valid = 1 -> ex_valid = 1, all controls 0.
